// File: rtl/i2c_sensor_poller.sv
// Command sequencer in front of the I2C master: one configuration write after reset,
// then an endless pointer-write / 16-bit read / hold loop that yields a valid-pulsed sample stream.
module i2c_sensor_poller #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h48,
  parameter logic [15:0] CFG_WORD       = 16'h0160,
  parameter logic [7:0]  PTR_BYTE       = 8'h00,
  parameter int          POLL_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        m_ready,
  input  logic [15:0] m_read_data,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic [15:0] m_data,
  output logic        m_rw,
  output logic        m_two_bytes,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] HOLD_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, COMPLETE, HOLD} state_t;
  typedef enum logic [1:0] {OP_CFG, OP_PTR, OP_RD} op_t;

  // {rw, two_bytes, data} presented to the master for each transaction kind
  function automatic logic [17:0] op_drive(input op_t op);
    case (op)
      OP_CFG:  op_drive = {1'b0, 1'b1, CFG_WORD};
      OP_PTR:  op_drive = {1'b0, 1'b0, 8'h00, PTR_BYTE};
      OP_RD:   op_drive = {1'b1, 1'b1, 16'h0000};
      default: op_drive = 18'h00000;
    endcase
  endfunction

  state_t         state_r, state_next_s;
  op_t            op_r, op_next_s;
  logic           cfg_done_r;
  logic [15:0]    sample_r;
  logic           sample_valid_r;
  logic [15:0]    m_data_r;
  logic           m_rw_r;
  logic           m_two_bytes_r;
  logic           timeout_err_r;
  logic           busy_r;
  logic [PW-1:0]  hold_cnt_r;
  logic [TW-1:0]  to_cnt_r;

  logic issue_s, cfg_set_s, sample_load_s, hold_load_s, hold_dec_s;
  logic to_clear_s, to_inc_s, timeout_s, start_s;

  // FSM state and current transaction selector
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      op_r    <= OP_CFG;
    end else begin
      state_r <= state_next_s;
      op_r    <= op_next_s;
    end
  end

  // Next-state decode; every decision point falls back to IDLE when enable is low
  always_comb begin
    state_next_s  = state_r;
    op_next_s     = op_r;
    issue_s       = 1'b0;
    cfg_set_s     = 1'b0;
    sample_load_s = 1'b0;
    hold_load_s   = 1'b0;
    hold_dec_s    = 1'b0;
    to_clear_s    = 1'b0;
    to_inc_s      = 1'b0;
    timeout_s     = 1'b0;
    start_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = ISSUE;
          issue_s      = 1'b1;
          op_next_s    = cfg_done_r ? OP_PTR : OP_CFG;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          start_s      = 1'b1;
          to_clear_s   = 1'b1;
          state_next_s = ACCEPT;
        end else begin
          state_next_s = ISSUE;
        end
      end
      ACCEPT: begin
        if (!m_ready) begin
          to_inc_s     = 1'b1;
          state_next_s = COMPLETE;
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s    = 1'b1;
          hold_load_s  = 1'b1;
          state_next_s = HOLD;
        end else begin
          to_inc_s     = 1'b1;
        end
      end
      COMPLETE: begin
        if (m_ready) begin
          case (op_r)
            OP_CFG: begin
              cfg_set_s = 1'b1;
              if (enable) begin
                state_next_s = ISSUE;
                op_next_s    = OP_PTR;
                issue_s      = 1'b1;
              end else begin
                state_next_s = IDLE;
              end
            end
            OP_PTR: begin
              if (enable) begin
                state_next_s = ISSUE;
                op_next_s    = OP_RD;
                issue_s      = 1'b1;
              end else begin
                state_next_s = IDLE;
              end
            end
            OP_RD: begin
              sample_load_s = 1'b1;
              if (enable) begin
                state_next_s = HOLD;
                hold_load_s  = 1'b1;
              end else begin
                state_next_s = IDLE;
              end
            end
            default: state_next_s = IDLE;
          endcase
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s    = 1'b1;
          hold_load_s  = 1'b1;
          state_next_s = HOLD;
        end else begin
          to_inc_s     = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_r == {PW{1'b0}}) begin
          if (enable) begin
            // a timed-out CFG leaves cfg_done clear, so this retries CFG
            state_next_s = ISSUE;
            op_next_s    = cfg_done_r ? OP_PTR : OP_CFG;
            issue_s      = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          hold_dec_s = 1'b1;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: master command registers, sample capture, counters and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_done_r     <= 1'b0;
      sample_r       <= 16'h0000;
      sample_valid_r <= 1'b0;
      m_data_r       <= 16'h0000;
      m_rw_r         <= 1'b0;
      m_two_bytes_r  <= 1'b0;
      timeout_err_r  <= 1'b0;
      busy_r         <= 1'b0;
      hold_cnt_r     <= {PW{1'b0}};
      to_cnt_r       <= {TW{1'b0}};
    end else begin
      busy_r         <= (state_next_s != IDLE);
      sample_valid_r <= sample_load_s;
      if (sample_load_s) sample_r <= m_read_data;
      if (cfg_set_s) cfg_done_r <= 1'b1;
      if (timeout_s) timeout_err_r <= 1'b1;
      if (issue_s) {m_rw_r, m_two_bytes_r, m_data_r} <= op_drive(op_next_s);
      // saturate so an exit on the last count cannot wrap into extra time
      if (to_clear_s) to_cnt_r <= {TW{1'b0}};
      else if (to_inc_s && (to_cnt_r != TO_LAST)) to_cnt_r <= to_cnt_r + TW'(1);
      if (hold_load_s) hold_cnt_r <= HOLD_LOAD;
      else if (hold_dec_s) hold_cnt_r <= hold_cnt_r - PW'(1);
    end
  end

  // start must coincide with the cycle ISSUE sees ready, so it is decoded directly
  assign m_start      = start_s;
  assign m_addr       = SLAVE_ADDR;
  assign m_data       = m_data_r;
  assign m_rw         = m_rw_r;
  assign m_two_bytes  = m_two_bytes_r;
  assign sample       = sample_r;
  assign sample_valid = sample_valid_r;
  assign busy         = busy_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Scoreboard bench for i2c_sensor_poller: a behavioural I2C master plus queues of
// expected transactions and samples checked as the sequencer produces them.
module tb_i2c_sensor_poller;

  localparam int P   = 20;
  localparam int T   = 64;
  localparam int LAT = 30;
  localparam logic [6:0]  ADDR     = 7'h48;
  localparam logic [17:0] EXP_CFG  = {1'b0, 1'b1, 16'h0160};
  localparam logic [17:0] EXP_PTR  = {1'b0, 1'b0, 16'h0000};
  localparam logic [17:0] EXP_RD   = {1'b1, 1'b1, 16'h0000};
  localparam int M_NORMAL = 0, M_STUCK_HIGH = 1;

  logic clk, rst, enable, m_ready;
  logic [15:0] m_read_data;
  logic m_start, m_rw, m_two_bytes, sample_valid, busy, timeout_err;
  logic [6:0] m_addr;
  logic [15:0] m_data, sample;

  i2c_sensor_poller #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .m_ready(m_ready), .m_read_data(m_read_data),
    .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
    .m_two_bytes(m_two_bytes), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0, start_cnt = 0, sv_cnt = 0, last_start = 0, last_rise = 0;
  int mode = M_NORMAL;
  bit busy_watch = 1'b0;
  logic [17:0] exp_ops[$];
  logic [15:0] exp_samples[$];
  logic [15:0] rd_vals[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, m_start, 0);
    check({tag, "_addr"}, m_addr, ADDR);
    check({tag, "_data"}, {m_rw, m_two_bytes, m_data}, 0);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_sv"}, sample_valid, 0);
    check({tag, "_to"}, timeout_err, 0);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (start_cnt < n && k < budget) begin @(posedge clk); k++; end
    check("wait_start", start_cnt >= n, 1);
  endtask

  task automatic wait_sv(input int n, input int budget);
    int k = 0;
    while (sv_cnt < n && k < budget) begin @(posedge clk); k++; end
    check("wait_sample", sv_cnt >= n, 1);
  endtask

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // behavioural master: ready drops the cycle after start, rises LAT cycles later
  initial begin
    int cnt = 0;
    bit pend = 1'b0, is_rd = 1'b0;
    logic [15:0] val = 16'h0000;
    m_ready = 1'b1; m_read_data = 16'h0000;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        m_ready = 1'b1; cnt = 0; pend = 1'b0;
      end else if (pend) begin
        pend = 1'b0; m_ready = 1'b0; cnt = LAT;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          m_ready = 1'b1; last_rise = cyc;
          if (is_rd) begin m_read_data = val; exp_samples.push_back(val); end
        end
      end else if (m_start && mode == M_NORMAL) begin
        pend = 1'b1; is_rd = m_rw;
        val = (rd_vals.size() > 0) ? rd_vals.pop_front() : 16'h0000;
      end
    end
  end

  // monitor: transactions and samples against the scoreboard queues
  initial begin
    logic prev_start = 1'b0, prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (m_start) begin
        start_cnt++; last_start = cyc;
        check("start_width", prev_start, 0);
        check("busy_at_start", busy, 1);
        check("addr", m_addr, ADDR);
        if (exp_ops.size() > 0) check("op", {m_rw, m_two_bytes, m_data}, exp_ops.pop_front());
        else check("op_queue_empty", exp_ops.size(), 1);
      end
      if (sample_valid) begin
        sv_cnt++;
        check("sv_width", prev_sv, 0);
        if (exp_samples.size() > 0) check("sample", sample, exp_samples.pop_front());
        else check("sample_queue_empty", exp_samples.size(), 1);
      end
      if (busy_watch) check("busy_run", busy, 1);
      prev_start = m_start; prev_sv = sample_valid;
    end
  end

  initial begin
    int s1, sv_base, k;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    // CFG, then three polls; enable dropped during the third RD
    exp_ops = '{EXP_CFG, EXP_PTR, EXP_RD, EXP_PTR, EXP_RD, EXP_PTR, EXP_RD};
    rd_vals = '{16'hBEEF, 16'h1234, 16'h5678};
    @(posedge clk); #1 enable = 1'b1;
    wait_starts(1, 100);
    busy_watch = 1'b1;
    wait_sv(1, 400);
    wait_starts(4, 200);
    check("poll_gap", last_start - last_rise, P + 1);
    wait_starts(7, 600);
    #1 enable = 1'b0; busy_watch = 1'b0;
    wait_sv(3, 200);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_no_start", start_cnt, 7);
    check("sv_total", sv_cnt, 3);
    check("ops_left", exp_ops.size(), 0);

    // re-enable goes straight to PTR; dropping enable then parks after PTR
    exp_ops.push_back(EXP_PTR);
    @(posedge clk); #1 enable = 1'b1;
    wait_starts(8, 100);
    #1 enable = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("ptr_idle_busy", busy, 0);
    check("ptr_idle_starts", start_cnt, 8);
    check("ptr_sv", sv_cnt, 3);

    // reset while the RD is in COMPLETE
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    exp_ops = '{EXP_CFG, EXP_PTR, EXP_RD};
    rd_vals.push_back(16'h0F0F);
    enable = 1'b1;
    wait_starts(11, 300);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1; sv_base = sv_cnt;
    @(posedge clk); @(negedge clk);
    check_reset("mid_rd_reset");
    check("mid_rd_no_sv", sv_cnt, sv_base);
    @(posedge clk); #1 rst = 1'b0;
    exp_ops = '{EXP_CFG, EXP_PTR};
    wait_starts(13, 200);
    #1 enable = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("restart_idle", busy, 0);
    check("restart_starts", start_cnt, 13);

    // master never drops ready: timeout, HOLD, CFG retry
    @(posedge clk); #1 rst = 1'b1; mode = M_STUCK_HIGH;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    exp_ops = '{EXP_CFG, EXP_CFG};
    @(posedge clk); #1 enable = 1'b1;
    wait_starts(14, 100);
    s1 = last_start; sv_base = sv_cnt; k = 0;
    do begin @(negedge clk); k++; end while (cyc < s1 + T && k < 500);
    check("timeout_early", timeout_err, 0);
    @(negedge clk);
    check("timeout_set", timeout_err, 1);
    check("timeout_busy", busy, 1);
    wait_starts(15, 300);
    #1 enable = 1'b0;
    check("retry_gap", last_start - s1, T + P + 1);
    repeat (T + P + 30) @(posedge clk);
    @(negedge clk);
    check("timeout_idle", busy, 0);
    check("timeout_sticky", timeout_err, 1);
    check("timeout_no_sv", sv_cnt, sv_base);
    check("timeout_starts", start_cnt, 15);
    check("final_ops_left", exp_ops.size(), 0);
    check("final_samples_left", exp_samples.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_poller.md
Name: i2c_sensor_poller

Overview:
- Command sequencer that sits directly upstream of the team's I2C master.
- It drives the master's data, addr, start, two_bytes and rw inputs, and consumes its ready and read_data outputs.
- After reset, when enabled, it writes one configuration word to a fixed slave once. It then loops forever: write the 1-byte register pointer, read a 16-bit sample, present the sample, wait a programmable interval.
- It gives the rest of the design a simple valid-pulsed sample stream with no knowledge of I2C.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit slave address used for every transaction.
- CFG_WORD, 16'h0160, configuration write sent once after reset as a 2-byte write (MSB first).
- PTR_BYTE, 8'h00, register pointer sent as a 1-byte write before every read.
- POLL_CYCLES, 1000, clk cycles spent in HOLD between the end of one read and the next pointer write (minimum 1).
- TIMEOUT_CYCLES, 4096, maximum clk cycles allowed per transaction, counted from start assertion to ready returning high.

Ports:
- clk  input  1  system clock; also the I2C master's clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = run the sequence; 0 = finish the current transaction, then park in IDLE.
- m_ready  input  1  ready from the I2C master.
- m_read_data  input  16  read_data from the I2C master.
- m_start  output  1  start pulse to the master.
- m_addr  output  7  address to the master.
- m_data  output  16  write data to the master.
- m_rw  output  1  0 = write, 1 = read.
- m_two_bytes  output  1  1 = 2 data bytes, 0 = 1 data byte.
- sample  output  16  last completed read value.
- sample_valid  output  1  one-cycle pulse when sample updates.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky flag, set on any transaction timeout.

Behaviour:
- Reset (rst high at a clk edge), from any state including mid-transaction:
  - state=IDLE, cfg_done=0, sample=0, sample_valid=0, m_start=0, m_addr=SLAVE_ADDR, m_data=0, m_rw=0, m_two_bytes=0, timeout_err=0, all counters 0.
  - The master is reset by the same rst.
- States: IDLE, ISSUE, ACCEPT, COMPLETE, HOLD.
- Transaction selector op ∈ {CFG, PTR, RD}, fixing the master inputs:
  - CFG: m_data=CFG_WORD, m_rw=0, m_two_bytes=1.
  - PTR: m_data={8'h00,PTR_BYTE}, m_rw=0, m_two_bytes=0.
  - RD: m_data=0, m_rw=1, m_two_bytes=1.
  - m_addr=SLAVE_ADDR always.
  - op and the m_* data outputs are registered. They are set on entry to ISSUE and held stable until the next ISSUE entry.
- IDLE:
  - If enable=1, go to ISSUE with op=CFG when cfg_done=0, else op=PTR.
- ISSUE:
  - Wait for m_ready=1. In the cycle it is seen, m_start=1 for exactly that one cycle, then go to ACCEPT.
  - The timeout counter clears on this transition.
- ACCEPT:
  - Wait for m_ready=0 (the master has left idle), then go to COMPLETE.
- COMPLETE:
  - Wait for m_ready=1, then:
    - op=CFG: set cfg_done=1, go to ISSUE with op=PTR.
    - op=PTR: go to ISSUE with op=RD.
    - op=RD: register sample<=m_read_data in the same edge, pulse sample_valid=1 in the following cycle, go to HOLD. The interval counter loads POLL_CYCLES-1.
- HOLD:
  - Decrement the interval counter each cycle. At 0, go to ISSUE with op=PTR if enable=1, else go to IDLE.
  - enable=0 in any other state does not abort. The current transaction completes and the FSM goes to IDLE at the next decision point: end of COMPLETE for PTR/RD, or HOLD exit.
  - A CFG that completes with enable=0 sets cfg_done and goes to IDLE.
- Timeout:
  - In ACCEPT and COMPLETE, the counter increments every cycle.
  - On reaching TIMEOUT_CYCLES-1 without the exit condition: set timeout_err=1, discard the op (no sample update, cfg_done unchanged), go to HOLD.
  - After HOLD, a CFG timeout retries CFG, since cfg_done is still 0.
  - timeout_err clears only on rst.
- NACK: the master gives no NACK indication. A NACKed transaction simply completes; for RD the master's returned data is taken as-is.
- Latency: start-to-start spacing is master transaction time plus 1 cycle (ISSUE sees ready). A RD completion is separated from the next PTR start by POLL_CYCLES+1 cycles.
- Counter widths: $clog2 of POLL_CYCLES and of TIMEOUT_CYCLES, each at least 1 bit.

Test Plan:
- Reset, enable=1, behavioural master holding ready low 30 cycles per transaction:
  - Sequence CFG(m_data=16'h0160, rw=0, two=1) -> PTR(16'h0000, rw=0, two=0) -> RD(rw=1, two=1).
  - Each m_start is exactly 1 cycle and busy=1 throughout.
- Master returns 16'hBEEF on RD -> sample=16'hBEEF and a single 1-cycle sample_valid. The next m_start (PTR) follows POLL_CYCLES+1 cycles after ready rose.
- Two consecutive polls returning 16'h1234 then 16'h5678:
  - CFG is not repeated.
  - sample_valid pulses exactly twice, with those values.
- Master never drops ready after start (or never raises it):
  - timeout_err=1 after TIMEOUT_CYCLES.
  - No sample_valid.
  - FSM reaches HOLD, then retries.
- enable dropped mid-RD:
  - The RD completes with sample_valid.
  - FSM goes to IDLE, busy=0, no further m_start.
  - Re-enable -> PTR directly (no CFG).
- rst asserted while in COMPLETE of RD:
  - Next cycle all outputs at reset values, sample unchanged at 0, no sample_valid.
  - After release, the sequence restarts with CFG.
